count_sched: RTL and testbench
==============================

Name: count_sched

Overview:
- Round-robin scheduler that shares one run/in_count/done count engine among N_REQ requesters.
- Sequences the engine: arbitrates, launches with the winner's length, waits for done, returns completion to the winner.
- Catches a hung engine with a timeout watchdog and latches a fault until software clears it.
- Sits between requester logic and the single shared counter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_SLACK, 16, extra cycles beyond requested length before a launch is declared hung

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester request level, sampled only in IDLE
- req_len  in  32*N_REQ  per-requester count length; requester i uses bits [32*i+31:32*i], held stable while req[i]=1
- gnt  out  N_REQ  one-cycle accept pulse, one-hot
- cmp  out  N_REQ  one-cycle completion pulse, one-hot, to the granted requester
- cmp_err  out  1  qualifies cmp: 1 = aborted by timeout
- busy  out  1  high in any state other than IDLE
- fault  out  1  high while in FAULT
- clr_fault  in  1  single-cycle pulse, exits FAULT
- cnt_run  out  1  one-cycle launch pulse to the engine
- cnt_len  out  32  length to the engine, held from launch until return to IDLE
- cnt_done  in  1  engine done pulse

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - RR pointer last = N_REQ-1, so requester 0 has priority first.
  - Timer 0.
- All outputs are registered.
- IDLE:
  - If req != 0, pick the winner w = first set bit searching last+1, last+2, ... with modulo-N_REQ wrap.
  - Latch w and len = req_len[w].
  - Go to LAUNCH (winner and len are registered in this cycle).
  - If req == 0, stay in IDLE.
- LAUNCH (1 cycle):
  - gnt[w]=1 and last<=w.
  - If len==0: skip the engine, because a zero length never completes; cnt_run=0, go to DONE with err=0.
  - Otherwise: cnt_run=1, cnt_len=len, timer<=0, go to WAIT.
- WAIT:
  - Timer increments each cycle; it is 33 bits wide, and len+TIMEOUT_SLACK is computed in 33 bits with no wrap.
  - If cnt_done=1, go to DONE with err=0.
  - Else if timer == len+TIMEOUT_SLACK, go to DONE with err=1 and set the fault flag.
  - If cnt_done and the timeout condition occur in the same cycle, cnt_done wins (err=0).
- DONE (1 cycle):
  - cmp[w]=1 and cmp_err=err.
  - If err=1, go to FAULT; otherwise go to IDLE.
- FAULT:
  - busy=1, fault=1, and no arbitration.
  - clr_fault=1 goes to IDLE and clears fault.
  - cnt_done received in FAULT is ignored.
- General rules:
  - cnt_done outside WAIT is ignored.
  - clr_fault outside FAULT is ignored.
- Latency:
  - From req sampled in IDLE at cycle T: gnt and cnt_run at T+1.
  - cnt_done at cycle D gives cmp at D+1.
  - Earliest new arbitration is at D+2.
- req is level-sensitive. A requester still asserting req after its cmp is re-arbitrated as a new request; it should drop req after gnt if it wants a single run.
- A request change during a busy interval has no effect until the next IDLE.
- Asynchronous reset mid-operation:
  - Immediate return to reset values.
  - Any outstanding cmp is lost.
  - The engine must be reset by the same rst_n.

Test Plan:
- Single request: req=4'b0001, req_len[0]=5, engine returns cnt_done 6 cycles after cnt_run -> gnt=0001 and cnt_run at T+1, cnt_len=5, cmp=0001 with cmp_err=0 one cycle after cnt_done, busy low the following cycle.
- Round-robin: req=4'b1111 held with all lengths 3 -> grant order 0,1,2,3,0; each gnt is one-hot; no requester is granted twice before all others.
- Zero length: req=4'b0100, req_len[2]=0 -> gnt=0100, no cnt_run pulse, cmp=0100 with cmp_err=0 one cycle after gnt.
- Timeout: req_len[1]=10, cnt_done never arrives -> cmp=0010 with cmp_err=1 exactly 26 cycles after cnt_run; fault=1; a new req is ignored until a clr_fault pulse; next arbitration happens in the cycle after the return to IDLE.
- Boundary tie: cnt_done asserted in the same cycle the timer hits len+TIMEOUT_SLACK -> cmp_err=0, fault stays 0. Stray cnt_done while IDLE -> no cmp, no state change.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs 0 immediately; after release, req=4'b0010 is granted before requester 0.

Source files
------------

// File: rtl/count_sched.sv
// Round-robin front end for one shared run/in_count/done count engine.
// Arbitrates requesters, launches the engine, watches for a hang, returns completion.
module count_sched #(
    parameter int N_REQ         = 4,
    parameter int TIMEOUT_SLACK = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_len,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      cmp,
    output logic                  cmp_err,
    output logic                  busy,
    output logic                  fault,
    input  logic                  clr_fault,
    output logic                  cnt_run,
    output logic [31:0]           cnt_len,
    input  logic                  cnt_done
);

    localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, FAULT} state_t;

    state_t         state;
    logic [W-1:0]   last;
    logic [W-1:0]   owner;
    logic [31:0]    len;
    logic           err;
    logic [32:0]    timer;

    logic [W-1:0]   win;
    logic           win_vld;
    logic [31:0]    sel_len;
    logic [32:0]    timer_nxt;
    logic [32:0]    limit;
    logic           timeout;

    function automatic logic [N_REQ-1:0] onehot(input logic [W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner is the first requester after the previous one, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_vld && req[W'((int'(last) + k) % N_REQ)]) begin
                win     = W'((int'(last) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end
        sel_len   = req_len[32*int'(win) +: 32];
        // timer_nxt counts cycles since cnt_run, including the launch cycle itself.
        timer_nxt = timer + 33'd1;
        limit     = {1'b0, len} + 33'(TIMEOUT_SLACK);
        timeout   = (timer_nxt == limit);
    end

    // Outputs are registered on the transition into the state that presents them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= W'(N_REQ - 1);
            owner   <= '0;
            len     <= '0;
            err     <= 1'b0;
            timer   <= '0;
            gnt     <= '0;
            cmp     <= '0;
            cmp_err <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            cnt_run <= 1'b0;
            cnt_len <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            gnt     <= '0;
            cmp     <= '0;
            cmp_err <= 1'b0;
            cnt_run <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= LAUNCH;
                        owner   <= win;
                        len     <= sel_len;
                        gnt     <= onehot(win);
                        cnt_run <= (sel_len != 32'd0);
                        cnt_len <= sel_len;
                        timer   <= '0;
                        busy    <= 1'b1;
                    end
                end
                LAUNCH: begin
                    last <= owner;
                    if (len == 32'd0) begin
                        // A zero-length count would never finish; complete without the engine.
                        state <= DONE;
                        err   <= 1'b0;
                        cmp   <= onehot(owner);
                    end else begin
                        state <= WAIT;
                        timer <= timer_nxt;
                    end
                end
                WAIT: begin
                    timer <= timer_nxt;
                    if (cnt_done) begin
                        state <= DONE;
                        err   <= 1'b0;
                        cmp   <= onehot(owner);
                    end else if (timeout) begin
                        state   <= DONE;
                        err     <= 1'b1;
                        cmp     <= onehot(owner);
                        cmp_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (err) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cnt_len <= '0;
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state   <= IDLE;
                        fault   <= 1'b0;
                        busy    <= 1'b0;
                        cnt_len <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: a scoreboard queue holds expected completions
// (vector, error flag, cycle) and a negedge monitor retires them as cmp appears.
module tb_count_sched;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    cmp;
    logic            cmp_err;
    logic            busy;
    logic            fault;
    logic            clr_fault;
    logic            cnt_run;
    logic [31:0]     cnt_len;
    logic            cnt_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] vec;
        logic         err;
        int           at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    count_sched #(.N_REQ(N), .TIMEOUT_SLACK(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .cmp       (cmp),
        .cmp_err   (cmp_err),
        .busy      (busy),
        .fault     (fault),
        .clr_fault (clr_fault),
        .cnt_run   (cnt_run),
        .cnt_len   (cnt_len),
        .cnt_done  (cnt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cmp(input logic [N-1:0] vec, input logic e, input int at);
        exp_t x;
        x.vec = vec;
        x.err = e;
        x.at  = at;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(output int at);
        int n = 0;
        while (gnt == '0 && n < 64) begin
            step();
            n++;
        end
        if (gnt == '0) begin
            checks++;
            errors++;
            $error("FAIL gnt_wait: observed no grant within 64 cycles, required a grant");
        end
        at = cyc;
    endtask

    // Completion monitor: every cmp pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && cmp != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL cmp_unexpected: observed cmp=%b, required none", cmp);
            end else begin
                mon_e = sb.pop_front();
                check("cmp_vec", 64'(cmp), 64'(mon_e.vec));
                check("cmp_err", 64'(cmp_err), 64'(mon_e.err));
                check("cmp_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int l;
        logic [N-1:0] rr_exp [5];

        rst_n = 1'b0; req = '0; req_len = '0; clr_fault = 1'b0; cnt_done = 1'b0;
        repeat (3) step();
        check("reset_outputs", 64'({gnt, cmp, cmp_err, busy, fault, cnt_run, cnt_len}), 64'd0);
        rst_n = 1'b1;
        step();

        // Round-robin with all four requesting, length 3, engine answers after 3 cycles.
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int i = 0; i < N; i++) req_len[32*i +: 32] = 32'd3;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(l);
            check("rr_gnt", 64'(gnt), 64'(rr_exp[g]));
            check("rr_run", 64'({cnt_run, cnt_len}), 64'({1'b1, 32'd3}));
            repeat (3) step();
            cnt_done = 1'b1;
            expect_cmp(rr_exp[g], 1'b0, cyc + 1);
            step();
            cnt_done = 1'b0;
            if (g == 4) req = '0;
        end
        repeat (3) step();

        // Single request, length 5, engine done 6 cycles after cnt_run.
        req_len[31:0] = 32'd5;
        req = 4'b0001;
        t = cyc;
        wait_gnt(l);
        check("single_gnt_latency", 64'(l), 64'(t + 1));
        check("single_launch", 64'({gnt, cnt_run, cnt_len, busy}), 64'({4'b0001, 1'b1, 32'd5, 1'b1}));
        req = '0;
        step();
        check("single_run_pulse", 64'({gnt, cnt_run}), 64'd0);
        repeat (5) step();
        cnt_done = 1'b1;
        expect_cmp(4'b0001, 1'b0, cyc + 1);
        step();
        cnt_done = 1'b0;
        check("single_busy_in_done", 64'(busy), 64'd1);
        step();
        check("single_busy_low", 64'(busy), 64'd0);
        step();

        // Zero length skips the engine entirely.
        req_len[95:64] = 32'd0;
        req = 4'b0100;
        wait_gnt(l);
        check("zero_gnt", 64'({gnt, cnt_run}), 64'({4'b0100, 1'b0}));
        expect_cmp(4'b0100, 1'b0, l + 1);
        req = '0;
        step();
        check("zero_no_run", 64'(cnt_run), 64'd0);
        repeat (3) step();

        // Timeout: length 10, no cnt_done, cmp with error 26 cycles after cnt_run.
        req_len[63:32] = 32'd10;
        req = 4'b0010;
        wait_gnt(l);
        check("to_gnt", 64'({gnt, cnt_run}), 64'({4'b0010, 1'b1}));
        expect_cmp(4'b0010, 1'b1, l + 26);
        req = '0;
        repeat (27) step();
        check("to_fault", 64'({fault, busy}), 64'({1'b1, 1'b1}));
        req_len[31:0] = 32'd2;
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cnt_done = (i == 2);
            step();
            check("fault_holds", 64'({gnt, fault, cnt_run}), 64'({4'b0000, 1'b1, 1'b0}));
        end
        cnt_done = 1'b0;
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        check("clr_fault_exit", 64'({fault, busy, gnt}), 64'd0);
        step();
        check("post_fault_gnt", 64'(gnt), 64'(4'b0001));
        req = '0;
        l = cyc;
        step();
        cnt_done = 1'b1;
        expect_cmp(4'b0001, 1'b0, l + 2);
        step();
        cnt_done = 1'b0;
        repeat (3) step();

        // Tie: cnt_done on the same cycle the timeout would fire; done wins.
        req = 4'b0010;
        wait_gnt(l);
        check("tie_gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        repeat (25) step();
        cnt_done = 1'b1;
        expect_cmp(4'b0010, 1'b0, l + 26);
        step();
        cnt_done = 1'b0;
        step();
        check("tie_no_fault", 64'({fault, busy}), 64'd0);

        // Stray cnt_done while idle changes nothing.
        cnt_done = 1'b1;
        step();
        cnt_done = 1'b0;
        check("stray_done", 64'({cmp, busy, gnt}), 64'd0);
        step();
        check("stray_done_after", 64'({cmp, busy, fault}), 64'd0);

        // Asynchronous reset in WAIT drops the run; pointer restarts.
        req_len[31:0] = 32'd20;
        req = 4'b0001;
        wait_gnt(l);
        req = '0;
        repeat (3) step();
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({gnt, cmp, cmp_err, busy, fault, cnt_run, cnt_len}), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        req_len[63:32] = 32'd2;
        req = 4'b0010;
        t = cyc;
        wait_gnt(l);
        check("post_reset_gnt", 64'(gnt), 64'(4'b0010));
        check("post_reset_latency", 64'(l), 64'(t + 1));
        req = '0;
        step();
        cnt_done = 1'b1;
        expect_cmp(4'b0010, 1'b0, cyc + 1);
        step();
        cnt_done = 1'b0;
        repeat (4) step();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
